// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//   Pipeline-side handshake between the MEM stage and the SRAM controller.
//
//   Signals:
//     wr_en       store request, held until ready=1
//     rd_en       load request, held until ready=1
//     address     byte address from the ALU result
//     write_data  store data
//     read_data   load result, valid when ready=1 at completion
//     ready       1 = no stall, 0 = core must freeze
//
//   Modports:
//     master  the pipeline (drives requests, observes ready/read_data)
//     slave   the controller (observes requests, drives ready/read_data)
// -----------------------------------------------------------------------------
interface sram_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output wr_en,
      output rd_en,
      output address,
      output write_data,
      input  read_data,
      input  ready
   );

   modport slave (
      input  wr_en,
      input  rd_en,
      input  address,
      input  write_data,
      output read_data,
      output ready
   );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Initiator side of a 32-bit asynchronous SRAM. Turns single-word load/store
//   requests from the MEM stage into a timed SRAM access that holds the bus for
//   WAIT_CYCLES cycles, stalling the core through ready=0 until it completes.
//
//   Sequence per access: IDLE (request seen) -> ACCESS x WAIT_CYCLES -> DONE
//   (ready=1 for one cycle) -> IDLE.
//
//   Parameters:
//     WAIT_CYCLES  cycles the SRAM bus is held per access (>= 1)
//     BASE_ADDR    byte address mapped to SRAM word 0
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-low reset
//     pipe       pipeline handshake (sram_controller_if.slave)
//     SRAM_ADDR  SRAM word address
//     SRAM_WE_N  active-low write enable
//     SRAM_DQ    bidirectional data bus (driven only during a write access)
//
//   Build option:
//     SRAM_READ_BUFFER_EN  adds a one-entry read buffer; a load that hits the
//                          buffered word completes with no stall and no bus
//                          traffic.
// -----------------------------------------------------------------------------
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic                clk,
   input  logic                rst,
   sram_controller_if.slave    pipe,
   output logic [16:0]         SRAM_ADDR,
   output logic                SRAM_WE_N,
   inout  wire  [31:0]         SRAM_DQ
);

   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_counter;
   logic          r_op_write;
   logic [16:0]   r_word;
   logic [31:0]   r_wdata;
   logic [31:0]   r_read_data;

   logic          w_req;
   logic          w_start;
   logic          w_last;
   logic          w_ready;
   logic          w_dq_oe;
   logic          w_hit;
   logic [31:0]   w_buf_data;
   logic [31:0]   w_offset;
   logic [16:0]   w_word;
   logic          w_unused_bits;

   // Address map: subtract the base first so a non-word-aligned BASE_ADDR
   // still borrows correctly, then drop the byte offset. Addresses below the
   // base wrap modulo 2^17 words.
   assign w_offset      = pipe.address - BASE_ADDR;
   assign w_word        = w_offset[18:2];
   assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

   assign w_req = pipe.wr_en | pipe.rd_en;

   // ---------------------------------------------------------------------------
   // Optional one-entry read buffer
   // ---------------------------------------------------------------------------
`ifdef SRAM_READ_BUFFER_EN
   logic        r_buf_valid;
   logic [16:0] r_buf_tag;
   logic [31:0] r_buf_data;

   // Only a load in IDLE can hit; a store (which wins over a load) never does.
   assign w_hit = (r_state == IDLE) && pipe.rd_en && !pipe.wr_en &&
                  r_buf_valid && (r_buf_tag == w_word);
   assign w_buf_data = r_buf_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_valid <= 1'b0;
      end else if (w_last && !r_op_write) begin
         r_buf_valid <= 1'b1;
      end
   end

   // NOTE: tag and data are qualified by r_buf_valid, so only the valid bit
   // needs a reset; the storage itself is left unreset like any RAM.
   always_ff @(posedge clk) begin
      if (w_last && !r_op_write) begin
         r_buf_tag  <= r_word;
         r_buf_data <= SRAM_DQ;
      end else if ((r_state == DONE) && r_op_write && r_buf_valid &&
                   (r_buf_tag == r_word)) begin
         // Keep the buffer coherent with a store to the buffered word.
         r_buf_data <= r_wdata;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_buf_data = r_read_data;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and handshake
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b1;
      w_start     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            // ready drops in the same cycle the request is seen.
            if (w_req && !w_hit) begin
               w_ready     = 1'b0;
               w_start     = 1'b1;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            w_ready = 1'b0;
            if (r_counter == LAST_COUNT) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: request latch, wait counter, read capture
   // ---------------------------------------------------------------------------
   // NOTE: state updates use non-blocking assignments so every register here
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_counter   <= '0;
         r_op_write  <= 1'b0;
         r_word      <= '0;
         r_wdata     <= '0;
         r_read_data <= '0;
      end else begin
         if (w_start) begin
            // Request is latched once; later changes on the pipeline side are
            // ignored until the access completes.
            r_op_write <= pipe.wr_en;
            r_word     <= w_word;
            r_wdata    <= pipe.write_data;
            r_counter  <= '0;
         end else if (r_state == ACCESS) begin
            r_counter <= r_counter + 1'b1;
         end

         if (w_last && !r_op_write) begin
            r_read_data <= SRAM_DQ;
         end else if (w_hit) begin
            r_read_data <= w_buf_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Bus outputs
   // ---------------------------------------------------------------------------
   // WE_N and the DQ enable are decoded straight from the state register, so an
   // asynchronous reset releases the bus at once without waiting for a clock.
   assign w_dq_oe   = (r_state == ACCESS) && r_op_write;
   assign SRAM_WE_N = ~w_dq_oe;
   assign SRAM_ADDR = r_word;
   assign SRAM_DQ   = w_dq_oe ? r_wdata : 'z;

   assign pipe.ready     = w_ready;
   assign pipe.read_data = w_hit ? w_buf_data : r_read_data;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

   logic        clk;
   logic        rst;
   logic [16:0] sram_addr;
   logic        sram_we_n;
   wire  [31:0] sram_dq;

   logic [31:0] mem [0:127];

   int n_vec;
   int n_err;

   sram_controller_if pipe ();

   sram_controller #(
      .WAIT_CYCLES (4),
      .BASE_ADDR   (32'd1024)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pipe      (pipe.slave),
      .SRAM_ADDR (sram_addr),
      .SRAM_WE_N (sram_we_n),
      .SRAM_DQ   (sram_dq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM device model: output enable tied active, so it drives DQ whenever
   // WE_N is high; a store is taken on each clock edge while WE_N is low.
   assign sram_dq = sram_we_n ? mem[sram_addr[6:0]] : 'z;

   always @(posedge clk) begin
      if (!sram_we_n) mem[sram_addr[6:0]] <= sram_dq;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one request just after a rising edge and holds it until ready=1.
   // Returns stall cycles, WE_N-low cycles, enable/WE_N disagreements, the last
   // SRAM address seen while stalled, and read_data at completion.
   task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         output int stall, output int we_low, output int clash,
                         output logic [31:0] bus_addr, output logic [31:0] rdata);
      bit done;
      pipe.wr_en      = is_wr;
      pipe.rd_en      = ~is_wr;
      pipe.address    = addr;
      pipe.write_data = data;
      stall    = 0;
      we_low   = 0;
      clash    = 0;
      bus_addr = '0;
      rdata    = '0;
      done     = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (dut.w_dq_oe !== ~sram_we_n) clash++;
         if (!sram_we_n) we_low++;
         if (pipe.ready) begin
            done  = 1'b1;
            rdata = pipe.read_data;
         end else begin
            stall++;
            bus_addr = {15'd0, sram_addr};
         end
      end
      if (!done) check("timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      pipe.wr_en = 1'b0;
      pipe.rd_en = 1'b0;
   endtask

   int          st, wl, cl;
   logic [31:0] ba, rd;
   int          hit_stall;

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
`ifdef SRAM_READ_BUFFER_EN
      hit_stall = 0;
`else
      hit_stall = 5;
`endif
      rst             = 1'b0;
      pipe.wr_en      = 1'b0;
      pipe.rd_en      = 1'b0;
      pipe.address    = 32'h0;
      pipe.write_data = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_ready", {31'd0, pipe.ready}, 32'd1);
      check("rst_dq_oe", {31'd0, dut.w_dq_oe}, 32'd0);
      check("rst_read_data", pipe.read_data, 32'h0);
      check("rst_addr", {15'd0, sram_addr}, 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ready", {31'd0, pipe.ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      @(posedge clk);
      #1;

      // Single write then read of word 1
      access(1'b1, 32'd1028, 32'hDEADBEEF, st, wl, cl, ba, rd);
      check("wr_stall", st, 32'd5);
      check("wr_we_low", wl, 32'd4);
      check("wr_addr", ba, 32'd1);
      check("wr_clash", cl, 32'd0);
      check("wr_mem1", mem[1], 32'hDEADBEEF);

      access(1'b0, 32'd1028, 32'h0, st, wl, cl, ba, rd);
      check("rd_stall", st, 32'd5);
      check("rd_we_low", wl, 32'd0);
      check("rd_addr", ba, 32'd1);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_clash", cl, 32'd0);

      // Repeat read of the same word: buffered hit or full access
      access(1'b0, 32'd1028, 32'h0, st, wl, cl, ba, rd);
      check("rd2_stall", st, hit_stall);
      check("rd2_data", rd, 32'hDEADBEEF);
      check("rd2_we_low", wl, 32'd0);

      // Back-to-back write / read / write
      access(1'b1, 32'd1024, 32'h11111111, st, wl, cl, ba, rd);
      check("b2b_wr0_stall", st, 32'd5);
      check("b2b_wr0_clash", cl, 32'd0);
      access(1'b0, 32'd1024, 32'h0, st, wl, cl, ba, rd);
      check("b2b_rd0_stall", st, 32'd5);
      check("b2b_rd0_data", rd, 32'h11111111);
      check("b2b_rd0_addr", ba, 32'd0);
      access(1'b1, 32'd1032, 32'h22222222, st, wl, cl, ba, rd);
      check("b2b_wr2_stall", st, 32'd5);
      check("b2b_wr2_addr", ba, 32'd2);
      check("b2b_wr2_clash", cl, 32'd0);
      check("b2b_mem2", mem[2], 32'h22222222);
      check("b2b_mem0", mem[0], 32'h11111111);

      // read_data holds across stores and idle cycles
      @(negedge clk);
      check("hold_read_data", pipe.read_data, 32'h11111111);
      @(posedge clk);
      #1;

      // Address below the base wraps to the top word
      access(1'b1, 32'd1020, 32'hCAFEF00D, st, wl, cl, ba, rd);
      check("wrap_addr", ba, 32'h0001FFFF);
      check("wrap_mem", mem[127], 32'hCAFEF00D);

      // Byte offset bits are ignored: 1031 is word 1
      access(1'b0, 32'd1031, 32'h0, st, wl, cl, ba, rd);
      check("offs_stall", st, 32'd5);
      check("offs_addr", ba, 32'd1);
      check("offs_data", rd, 32'hDEADBEEF);

      // Store to the most recently read word, then read it again
      access(1'b1, 32'd1028, 32'h44444444, st, wl, cl, ba, rd);
      check("upd_wr_stall", st, 32'd5);
      access(1'b0, 32'd1028, 32'h0, st, wl, cl, ba, rd);
      check("upd_rd_stall", st, hit_stall);
      check("upd_rd_data", rd, 32'h44444444);

      // Reset during the second ACCESS cycle of a write
      pipe.wr_en      = 1'b1;
      pipe.address    = 32'd1036;
      pipe.write_data = 32'h33333333;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_we_n_pre", {31'd0, sram_we_n}, 32'd0);
      rst = 1'b0;
      #1;
      check("mid_we_n_rst", {31'd0, sram_we_n}, 32'd1);
      check("mid_dq_oe_rst", {31'd0, dut.w_dq_oe}, 32'd0);
      pipe.wr_en = 1'b0;
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_ready_after", {31'd0, pipe.ready}, 32'd1);
      check("mid_we_n_after", {31'd0, sram_we_n}, 32'd1);
      check("mid_read_data", pipe.read_data, 32'h0);
      @(negedge clk);
      check("mid_ready_idle", {31'd0, pipe.ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the external 32-bit SRAM interface. Sits between the MEM pipeline stage and the SRAM device.
- Converts single-word load/store requests from the pipeline into timed SRAM_ADDR/SRAM_WE_N/SRAM_DQ transactions.
- Holds `ready` low so the core stalls until the access completes.
- Covers the device's 30 ns read-data delay with a programmable number of wait cycles.

Parameters:
- WAIT_CYCLES, 4, number of cycles the SRAM bus is held per access (min 1); must cover the 30 ns device delay at the system clock.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  store request; held by the pipeline until ready=1.
- rd_en  input  1  load request; held by the pipeline until ready=1.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data.
- read_data  output  32  load result; valid when ready=1 at completion.
- ready  output  1  1 = no stall; 0 = core must freeze.
- SRAM_ADDR  output  17  SRAM word address.
- SRAM_WE_N  output  1  active-low write enable.
- SRAM_DQ  inout  32  bidirectional data bus.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, read_data=0, latched op/addr/data cleared.
  - Reset mid-access aborts immediately: WE_N rises without waiting for clk, and no completion is reported.
- Address map: word = (address - BASE_ADDR) >> 2, truncated to [16:0]. Bits [1:0] are ignored. No range check; addresses below BASE_ADDR wrap modulo 2^17 words.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: ready=1 and the bus is idle (WE_N=1, DQ=Z).
  - rd_en or wr_en: ready=0 combinationally in the same cycle. Latch op, word address and write_data; counter←0; next state ACCESS.
  - wr_en and rd_en together: write wins.
- ACCESS:
  - ready=0. SRAM_ADDR = latched word.
  - Write: SRAM_WE_N=0 and SRAM_DQ = latched data for every ACCESS cycle.
  - Read: SRAM_WE_N=1 and SRAM_DQ=Z.
  - counter increments each cycle. When counter==WAIT_CYCLES-1: for a read, read_data←SRAM_DQ at that edge; next state DONE.
- DONE:
  - ready=1 for exactly one cycle. SRAM_WE_N=1, SRAM_DQ=Z, read_data stable. Next state IDLE.
- Latency: request seen in cycle 0 → DONE in cycle WAIT_CYCLES+1. Stall is WAIT_CYCLES+1 cycles. Total access is WAIT_CYCLES+2 cycles.
- Back-to-back: the pipeline advances at the DONE edge. A new request in the following IDLE cycle starts immediately; there are no lost cycles beyond the single IDLE cycle.
- Bus contention: SRAM_DQ is driven only in ACCESS with a write op. SRAM_WE_N is high in every cycle where DQ is Z.
- Requests are not re-sampled during ACCESS/DONE. Changes to address, write_data, wr_en or rd_en mid-access are ignored.
- read_data holds its last value across writes and idle cycles.

Optional Feature:
- Macro: SRAM_READ_BUFFER_EN.
- With the macro defined, a one-entry read buffer (valid, word tag, data) is added:
  - A read in IDLE whose word matches a valid tag is a hit: ready stays 1 in the same cycle, read_data shows the buffered data combinationally, and no SRAM access occurs.
  - Every completed read fills the buffer.
  - A write to the tagged word updates the buffer data at the write's DONE.
  - Reset clears valid.
- Without the macro, every read performs a full SRAM access.

Test Plan:
- Reset: hold rst=0 → SRAM_WE_N=1, ready=1, SRAM_DQ=Z, read_data=0; release → still idle, with no bus activity and no requests.
- Write: wr_en=1, address=1028, write_data=0xDEADBEEF → ready low 5 cycles; SRAM_ADDR=1 and SRAM_WE_N=0 for 4 cycles; then DONE with ready=1; SRAM word 1 = 0xDEADBEEF.
- Read: rd_en=1, address=1028 after the write → ready low 5 cycles; read_data=0xDEADBEEF when ready returns to 1; SRAM_DQ never driven by the controller.
- Back-to-back: write 0x11111111@1024, then read @1024, then write 0x22222222@1032 → each completes in 6 cycles; read returns 0x11111111; SRAM word 2 = 0x22222222; no DQ contention (WE_N=1 whenever DQ is Z).
- Reset mid-write: assert rst=0 on the 2nd ACCESS cycle → SRAM_WE_N=1 and SRAM_DQ=Z before the next clk edge; after release, state is IDLE and ready=1.
- Read buffer: two consecutive reads @1028 → with SRAM_READ_BUFFER_EN, the second read gives 0 stall cycles and 0xDEADBEEF; without the macro, both reads stall 5 cycles.
